// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: elastic pixel buffer in front of the VGA data-stream stage.
// Producer pushes {sof, pixel} over valid/ready; pixels are released one per
// pixel_req cycle once the stream has been aligned to a frame_start pulse.
// Underflow or frame misalignment drops back to ALIGN and bumps err_count.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   ALIGN  | discard untagged heads until a sof-tagged pixel sits at the head
//   ARMED  | sof pixel held at head, waiting for frame_start
//   STREAM | locked; one pop per pixel_req, sof tag must match frame_start
module vga_pixel_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_sof,
  output logic                s_ready,
  input  logic                pixel_req,
  input  logic                frame_start,
  output logic [DATA_W-1:0]   rgb_data,
  output logic [ADDR_W:0]     level,
  output logic [ERR_W-1:0]    err_count,
  output logic                locked
);

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  // storage: bit DATA_W holds the sof tag
  logic [DATA_W:0]     mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     level_q, level_d;
  state_t              state_q, state_d;
  logic                locked_q;
  logic [DATA_W-1:0]   rgb_q, rgb_d;
  logic [ERR_W-1:0]    err_q;

  logic                empty;
  logic                push;
  logic                pop;
  logic                err_evt;
  logic                head_sof;
  logic [DATA_W-1:0]   head_pix;

  assign empty    = (level_q == '0);
  assign s_ready  = (level_q != LVL_FULL);
  assign push     = s_valid && s_ready;
  assign head_sof = mem_q[rd_ptr_q][DATA_W];
  assign head_pix = mem_q[rd_ptr_q][DATA_W-1:0];

  assign rgb_data  = rgb_q;
  assign level     = level_q;
  assign err_count = err_q;
  assign locked    = locked_q;

  // Storage array: no reset, contents are invalidated by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_sof, s_data};
    end
  end

  // Pop / error decisions and next state; rgb_data defaults to blank.
  always_comb begin
    pop     = 1'b0;
    err_evt = 1'b0;
    state_d = state_q;
    rgb_d   = '0;
    unique case (state_q)
      ALIGN: begin
        if (!empty) begin
          if (head_sof) begin
            state_d = ARMED;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ARMED: begin
        if (frame_start && !empty) begin
          pop     = 1'b1;
          rgb_d   = head_pix;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pixel_req) begin
          if (empty) begin
            err_evt = 1'b1;
            state_d = ALIGN;
          end else if (head_sof != frame_start) begin
            // leave the head in place so ALIGN can re-arm on a sof entry
            err_evt = 1'b1;
            state_d = ALIGN;
          end else begin
            pop   = 1'b1;
            rgb_d = head_pix;
          end
        end
      end
      default: begin
        state_d = ALIGN;
      end
    endcase
  end

  // Occupancy next value; push is already blocked when full.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointers and registered occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // FSM state with registered outputs: locked, rgb_data, saturating err_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALIGN;
      locked_q <= 1'b0;
      rgb_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == STREAM);
      rgb_q    <= rgb_d;
      if (err_evt && (err_q != ERR_MAX)) begin
        err_q <= err_q + 1'b1;
      end
    end
  end

endmodule
